// File: rtl/branch_resolve_bht_if.sv
// Branch resolution / BHT bus bundle: IF-side lookup, EX-side resolve
// request, registered redirect/status and the optional statistics counters.
interface branch_resolve_bht_if #(
   parameter int XLEN = 32
);
   logic [XLEN-1:0] i_if_pc;
   logic            o_if_pred_taken;
   logic            i_ex_valid;
   logic [XLEN-1:0] i_ex_pc;
   logic [XLEN-1:0] i_ex_rs1;
   logic [XLEN-1:0] i_ex_rs2;
   logic [XLEN-1:0] i_ex_imm;
   logic [2:0]      i_ex_funct3;
   logic            i_ex_branch;
   logic            i_ex_jal;
   logic            i_ex_jalr;
   logic            i_ex_pred_taken;
   logic [XLEN-1:0] i_ex_pred_target;
   logic            i_flush;
   logic            o_redirect;
   logic [XLEN-1:0] o_redirect_pc;
   logic            o_taken;
   logic            o_br_illegal;
   logic [31:0]     o_stat_branches;
   logic [31:0]     o_stat_mispred;

   modport master (
      output i_if_pc, i_ex_valid, i_ex_pc, i_ex_rs1, i_ex_rs2, i_ex_imm,
             i_ex_funct3, i_ex_branch, i_ex_jal, i_ex_jalr, i_ex_pred_taken,
             i_ex_pred_target, i_flush,
      input  o_if_pred_taken, o_redirect, o_redirect_pc, o_taken,
             o_br_illegal, o_stat_branches, o_stat_mispred
   );

   modport slave (
      input  i_if_pc, i_ex_valid, i_ex_pc, i_ex_rs1, i_ex_rs2, i_ex_imm,
             i_ex_funct3, i_ex_branch, i_ex_jal, i_ex_jalr, i_ex_pred_taken,
             i_ex_pred_target, i_flush,
      output o_if_pred_taken, o_redirect, o_redirect_pc, o_taken,
             o_br_illegal, o_stat_branches, o_stat_mispred
   );
endinterface

// File: rtl/branch_resolve_bht.sv
// Branch resolution unit with a bimodal branch history table.
// EX side resolves BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR and raises a registered
// redirect on mispredict; IF side reads a 2-bit counter MSB combinationally.
// Optional macro BRANCH_STATS_EN adds saturating resolve/mispredict counters;
// without it the statistics outputs are tied to zero.
module branch_resolve_bht #(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64
) (
   input logic                i_clk,
   input logic                i_rst,
   branch_resolve_bht_if.slave bus
);
   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic [1:0]       bht [BHT_ENTRIES];
   logic [IDX_W-1:0] if_idx;
   logic [IDX_W-1:0] ex_idx;

   logic            is_jal, is_jalr, is_br, res;
   logic [XLEN:0]   diff;
   logic            eq, lt, ltu, ovf;
   logic            cond, bad_f3, taken, illegal, mispredict, train;
   logic [XLEN-1:0] br_target, jalr_sum, target, fallthrough;
   logic [1:0]      ctr, ctr_next;

   assign if_idx = bus.i_if_pc[IDX_W+1:2];
   assign ex_idx = bus.i_ex_pc[IDX_W+1:2];

   // No bypass: a same-cycle update to this index shows up next cycle.
   assign bus.o_if_pred_taken = bht[if_idx][1];

   // Type priority when several bits are set: jal > jalr > branch.
   assign is_jal  = bus.i_ex_jal;
   assign is_jalr = ~bus.i_ex_jal & bus.i_ex_jalr;
   assign is_br   = ~bus.i_ex_jal & ~bus.i_ex_jalr & bus.i_ex_branch;
   assign res     = bus.i_ex_valid & ~bus.i_flush & (is_jal | is_jalr | is_br);

   // One XLEN+1 subtract feeds all compares: borrow for unsigned,
   // sign xor overflow for signed.
   assign diff = {1'b0, bus.i_ex_rs1} - {1'b0, bus.i_ex_rs2};
   assign eq   = (bus.i_ex_rs1 == bus.i_ex_rs2);
   assign ltu  = diff[XLEN];
   assign ovf  = (bus.i_ex_rs1[XLEN-1] ^ bus.i_ex_rs2[XLEN-1]) &
                 (diff[XLEN-1] ^ bus.i_ex_rs1[XLEN-1]);
   assign lt   = diff[XLEN-1] ^ ovf;

   // Branch condition decode; 010/011 are not branch encodings.
   always_comb begin
      cond   = 1'b0;
      bad_f3 = 1'b0;
      case (bus.i_ex_funct3)
         3'b000: cond = eq;
         3'b001: cond = ~eq;
         3'b010: bad_f3 = 1'b1;
         3'b011: bad_f3 = 1'b1;
         3'b100: cond = lt;
         3'b101: cond = ~lt;
         3'b110: cond = ltu;
         3'b111: cond = ~ltu;
      endcase
   end

   assign br_target   = bus.i_ex_pc + bus.i_ex_imm;
   assign jalr_sum    = bus.i_ex_rs1 + bus.i_ex_imm;
   assign target      = is_jalr ? (jalr_sum & ~XLEN'(1)) : br_target;
   assign fallthrough = bus.i_ex_pc + XLEN'(4);
   assign taken       = is_br ? cond : 1'b1;
   assign illegal     = is_br & bad_f3;
   assign mispredict  = res & ((taken != bus.i_ex_pred_taken) |
                               (taken & (bus.i_ex_pred_target != target)));
   assign train       = res & is_br & ~bad_f3;

   // Saturating 2-bit counter step for the EX instruction's entry.
   always_comb begin
      ctr      = bht[ex_idx];
      ctr_next = ctr;
      if (taken) begin
         if (ctr != 2'b11) ctr_next = ctr + 2'd1;
      end else begin
         if (ctr != 2'b00) ctr_next = ctr - 2'd1;
      end
   end

   // Counter table: reset to weakly not-taken, trained by legal branches only.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
      end else if (train) begin
         bht[ex_idx] <= ctr_next;
      end
   end

   // Registered resolve results; redirect pulses, the rest hold between resolves.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         bus.o_redirect    <= 1'b0;
         bus.o_redirect_pc <= '0;
         bus.o_taken       <= 1'b0;
         bus.o_br_illegal  <= 1'b0;
      end else begin
         bus.o_redirect <= mispredict;
         if (res) begin
            bus.o_redirect_pc <= taken ? target : fallthrough;
            bus.o_taken       <= taken;
            bus.o_br_illegal  <= illegal;
         end
      end
   end

`ifdef BRANCH_STATS_EN
   // Saturating resolve / mispredict counters.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         bus.o_stat_branches <= '0;
         bus.o_stat_mispred  <= '0;
      end else begin
         if (res && (bus.o_stat_branches != 32'hFFFF_FFFF))
            bus.o_stat_branches <= bus.o_stat_branches + 32'd1;
         if (mispredict && (bus.o_stat_mispred != 32'hFFFF_FFFF))
            bus.o_stat_mispred <= bus.o_stat_mispred + 32'd1;
      end
   end
`else
   assign bus.o_stat_branches = '0;
   assign bus.o_stat_mispred  = '0;
`endif

   logic unused_bits;
   assign unused_bits = ^{bus.i_if_pc[XLEN-1:IDX_W+2], bus.i_if_pc[1:0],
                          bus.i_ex_pc[XLEN-1:IDX_W+2], bus.i_ex_pc[1:0],
                          diff[XLEN-2:0]};
endmodule

// File: tb/tb_branch_resolve_bht.sv
// Bench for branch_resolve_bht: directed scenarios followed by random
// instructions, all checked against an arithmetic reference model.
module tb_branch_resolve_bht;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   branch_resolve_bht_if #(.XLEN(32)) bus ();
   branch_resolve_bht #(.XLEN(32), .BHT_ENTRIES(64)) dut (
      .i_clk(clk), .i_rst(rst), .bus(bus)
   );

   int n_assert = 0;
   int n_fail   = 0;

   int          m_cnt [64];
   logic        e_red, e_tk, e_ill;
   logic [31:0] e_rpc, e_sbr, e_smis;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int idx(input logic [31:0] pc);
      return int'(pc[7:2]);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 64; i++) m_cnt[i] = 1;
      e_red = 0; e_tk = 0; e_ill = 0; e_rpc = 0; e_sbr = 0; e_smis = 0;
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ":redirect"}, 32'(bus.o_redirect), 32'(e_red));
      chk({tag, ":rpc"}, bus.o_redirect_pc, e_rpc);
      chk({tag, ":taken"}, 32'(bus.o_taken), 32'(e_tk));
      chk({tag, ":illegal"}, 32'(bus.o_br_illegal), 32'(e_ill));
`ifdef BRANCH_STATS_EN
      chk({tag, ":stat_br"}, bus.o_stat_branches, e_sbr);
      chk({tag, ":stat_mis"}, bus.o_stat_mispred, e_smis);
`else
      chk({tag, ":stat_br"}, bus.o_stat_branches, 32'd0);
      chk({tag, ":stat_mis"}, bus.o_stat_mispred, 32'd0);
`endif
   endtask

   task automatic check_pred(input string tag, input logic [31:0] pc);
      bus.i_if_pc = pc;
      #1;
      chk(tag, 32'(bus.o_if_pred_taken), 32'(m_cnt[idx(pc)] >= 2));
   endtask

   // One EX cycle: drive, check the pre-update lookup, advance the model, clock, compare.
   task automatic ex(input string tag, input logic v, input logic fl,
                     input logic br, input logic jl, input logic jr,
                     input logic [2:0] f3, input logic [31:0] pc,
                     input logic [31:0] rs1, input logic [31:0] rs2,
                     input logic [31:0] imm, input logic pt, input logic [31:0] ptgt);
      logic        res, tk, ill, mis;
      logic [31:0] tgt;
      bus.i_ex_valid = v; bus.i_flush = fl;
      bus.i_ex_branch = br; bus.i_ex_jal = jl; bus.i_ex_jalr = jr;
      bus.i_ex_funct3 = f3; bus.i_ex_pc = pc;
      bus.i_ex_rs1 = rs1; bus.i_ex_rs2 = rs2; bus.i_ex_imm = imm;
      bus.i_ex_pred_taken = pt; bus.i_ex_pred_target = ptgt;
      #1;
      chk({tag, ":lookup"}, 32'(bus.o_if_pred_taken), 32'(m_cnt[idx(bus.i_if_pc)] >= 2));
      res = v && !fl && (br || jl || jr);
      e_red = 0;
      if (res) begin
         ill = 0;
         if (jl) begin
            tk = 1; tgt = pc + imm;
         end else if (jr) begin
            tk = 1; tgt = (rs1 + imm) & 32'hFFFF_FFFE;
         end else begin
            tgt = pc + imm;
            case (f3)
               3'd0: tk = (rs1 == rs2);
               3'd1: tk = (rs1 != rs2);
               3'd4: tk = ($signed(rs1) <  $signed(rs2));
               3'd5: tk = ($signed(rs1) >= $signed(rs2));
               3'd6: tk = (rs1 <  rs2);
               3'd7: tk = (rs1 >= rs2);
               default: begin tk = 0; ill = 1; end
            endcase
            if (!ill) begin
               if (tk) m_cnt[idx(pc)] = (m_cnt[idx(pc)] == 3) ? 3 : m_cnt[idx(pc)] + 1;
               else    m_cnt[idx(pc)] = (m_cnt[idx(pc)] == 0) ? 0 : m_cnt[idx(pc)] - 1;
            end
         end
         mis   = (tk != pt) || (tk && (ptgt != tgt));
         e_red = mis;
         e_rpc = tk ? tgt : pc + 4;
         e_tk  = tk;
         e_ill = ill;
         e_sbr = e_sbr + 1;
         if (mis) e_smis = e_smis + 1;
      end
      @(posedge clk); #1;
      check_outputs(tag);
   endtask

   task automatic idle();
      bus.i_ex_valid = 0; bus.i_flush = 0;
      bus.i_ex_branch = 0; bus.i_ex_jal = 0; bus.i_ex_jalr = 0;
   endtask

   // Reset while a mispredicting branch sits in EX: reset wins.
   task automatic do_reset(input string tag);
      rst = 1;
      bus.i_ex_valid = 1; bus.i_flush = 0;
      bus.i_ex_branch = 1; bus.i_ex_jal = 0; bus.i_ex_jalr = 0;
      bus.i_ex_funct3 = 3'b000; bus.i_ex_pc = 32'h40;
      bus.i_ex_rs1 = 7; bus.i_ex_rs2 = 7; bus.i_ex_imm = 32'h10;
      bus.i_ex_pred_taken = 0; bus.i_ex_pred_target = 0;
      @(posedge clk); #1;
      rst = 0;
      idle();
      model_reset();
      check_outputs(tag);
   endtask

   logic [31:0] pool [6];

   initial begin
      pool[0] = 32'h0; pool[1] = 32'h1; pool[2] = 32'hFFFF_FFFF;
      pool[3] = 32'h8000_0000; pool[4] = 32'h7FFF_FFFF; pool[5] = 32'h5;
      rst = 1; bus.i_if_pc = 0; idle();
      bus.i_ex_funct3 = 0; bus.i_ex_pc = 0; bus.i_ex_rs1 = 0; bus.i_ex_rs2 = 0;
      bus.i_ex_imm = 0; bus.i_ex_pred_taken = 0; bus.i_ex_pred_target = 0;
      @(posedge clk); @(posedge clk); #1;
      do_reset("reset");

      for (int i = 0; i < 64; i++) begin
         bus.i_if_pc = 32'(i * 4);
         #1;
         chk("sweep_pred", 32'(bus.o_if_pred_taken), 32'd0);
      end

      // Signed vs unsigned compare of -1 and 1.
      ex("blt", 1, 0, 1, 0, 0, 3'b100, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 0, 0);
      chk("blt_redirect", 32'(bus.o_redirect), 32'd1);
      chk("blt_pc", bus.o_redirect_pc, 32'h120);
      chk("blt_taken", 32'(bus.o_taken), 32'd1);
      ex("bltu", 1, 0, 1, 0, 0, 3'b110, 32'h100, 32'hFFFF_FFFF, 32'h1, 32'h20, 0, 0);
      chk("bltu_redirect", 32'(bus.o_redirect), 32'd0);
      chk("bltu_taken", 32'(bus.o_taken), 32'd0);

      // BEQ at 0x40: saturate up, then down.
      bus.i_if_pc = 32'h40;
      ex("beq_t0", 1, 0, 1, 0, 0, 3'b000, 32'h40, 5, 5, 32'h10, 0, 0);
      check_pred("beq_pred_after1", 32'h40);
      chk("beq_pred_after1_const", 32'(bus.o_if_pred_taken), 32'd1);
      ex("beq_t1", 1, 0, 1, 0, 0, 3'b000, 32'h40, 5, 5, 32'h10, 1, 32'h50);
      chk("beq_t1_noredirect", 32'(bus.o_redirect), 32'd0);
      ex("beq_t2", 1, 0, 1, 0, 0, 3'b000, 32'h40, 5, 5, 32'h10, 1, 32'h50);
      chk("beq_cnt_sat", 32'(m_cnt[16]), 32'd3);
      ex("beq_n0", 1, 0, 1, 0, 0, 3'b000, 32'h40, 5, 6, 32'h10, 1, 32'h50);
      check_pred("beq_pred_cnt2", 32'h40);
      ex("beq_n1", 1, 0, 1, 0, 0, 3'b000, 32'h40, 5, 6, 32'h10, 1, 32'h50);
      check_pred("beq_pred_cnt1", 32'h40);
      chk("beq_pred_cnt1_const", 32'(bus.o_if_pred_taken), 32'd0);
      ex("beq_n2", 1, 0, 1, 0, 0, 3'b000, 32'h40, 5, 6, 32'h10, 0, 0);
      chk("beq_cnt_floor", 32'(m_cnt[16]), 32'd0);

      // JALR target alignment, correct and wrong predicted target.
      ex("jalr_ok", 1, 0, 0, 0, 1, 3'b000, 32'h200, 32'h1003, 0, 32'h4, 1, 32'h1006);
      chk("jalr_ok_redirect", 32'(bus.o_redirect), 32'd0);
      ex("jalr_bad", 1, 0, 0, 0, 1, 3'b000, 32'h200, 32'h1003, 0, 32'h4, 1, 32'h1008);
      chk("jalr_bad_redirect", 32'(bus.o_redirect), 32'd1);
      chk("jalr_bad_pc", bus.o_redirect_pc, 32'h1006);
      check_pred("jalr_no_train", 32'h200);

      // Flushed mispredict and illegal funct3.
      ex("bne_flush", 1, 1, 1, 0, 0, 3'b001, 32'h80, 1, 2, 32'h8, 0, 0);
      chk("bne_flush_redirect", 32'(bus.o_redirect), 32'd0);
      check_pred("bne_flush_pred", 32'h80);
      ex("illegal", 1, 0, 1, 0, 0, 3'b010, 32'h80, 1, 1, 32'h8, 1, 32'h88);
      chk("illegal_flag", 32'(bus.o_br_illegal), 32'd1);
      chk("illegal_taken", 32'(bus.o_taken), 32'd0);
      chk("illegal_cnt", 32'(m_cnt[32]), 32'd1);
      idle(); @(posedge clk); #1;
      chk("redirect_pulse", 32'(bus.o_redirect), 32'd0);

      // Statistics: 5 resolves, 2 mispredicts.
      do_reset("stats_reset");
      ex("s1", 1, 0, 1, 0, 0, 3'b000, 32'h10, 3, 3, 32'h40, 1, 32'h50);
      ex("s2", 1, 0, 1, 0, 0, 3'b001, 32'h14, 3, 3, 32'h40, 0, 0);
      ex("s3", 1, 0, 1, 0, 0, 3'b000, 32'h18, 3, 3, 32'h40, 0, 0);
      ex("s4", 1, 0, 0, 1, 0, 3'b000, 32'h1C, 0, 0, 32'h40, 1, 32'h5C);
      ex("s5", 1, 0, 0, 1, 0, 3'b000, 32'h20, 0, 0, 32'h40, 1, 32'h0);
`ifdef BRANCH_STATS_EN
      chk("stats_br5", bus.o_stat_branches, 32'd5);
      chk("stats_mis2", bus.o_stat_mispred, 32'd2);
`else
      chk("stats_off_br", bus.o_stat_branches, 32'd0);
      chk("stats_off_mis", bus.o_stat_mispred, 32'd0);
`endif
      do_reset("midrun_reset");
      chk("midrun_redirect", 32'(bus.o_redirect), 32'd0);
      chk("midrun_stat", bus.o_stat_branches, 32'd0);
      check_pred("midrun_pred", 32'h40);

      // Random instructions.
      for (int n = 0; n < 400; n++) begin
         logic        v, fl, br, jl, jr, pt;
         logic [2:0]  f3;
         logic [31:0] pc, rs1, rs2, imm, ptgt;
         v   = ($urandom_range(0, 7) != 0);
         fl  = ($urandom_range(0, 7) == 0);
         case ($urandom_range(0, 9))
            0:       begin br = 0; jl = 1; jr = 0; end
            1:       begin br = 0; jl = 0; jr = 1; end
            2:       begin br = 1; jl = $urandom_range(0, 1); jr = $urandom_range(0, 1); end
            3:       begin br = 0; jl = 0; jr = 0; end
            default: begin br = 1; jl = 0; jr = 0; end
         endcase
         f3  = 3'($urandom_range(0, 7));
         pc  = {$urandom_range(0, 3) == 0 ? 24'($urandom) : 24'h0,
                6'($urandom_range(0, 7)), 2'b00};
         rs1 = ($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 5)] : $urandom;
         rs2 = ($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 5)] : $urandom;
         if ($urandom_range(0, 3) == 0) rs2 = rs1;
         imm = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 255)) : $urandom;
         pt  = $urandom_range(0, 1);
         case ($urandom_range(0, 2))
            0:       ptgt = pc + imm;
            1:       ptgt = (rs1 + imm) & 32'hFFFF_FFFE;
            default: ptgt = $urandom;
         endcase
         bus.i_if_pc = {24'h0, 6'($urandom_range(0, 7)), 2'b00};
         ex("rand", v, fl, br, jl, jr, f3, pc, rs1, rs2, imm, pt, ptgt);
         if (n == 200) do_reset("rand_reset");
      end

      for (int i = 0; i < 8; i++) check_pred("final_pred", 32'(i * 4));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/branch_resolve_bht.md
Name: branch_resolve_bht

Overview:
Parametrised branch resolution unit for the pipelined RISC-V core, with a bimodal branch history table (BHT).
- EX side: evaluates BEQ/BNE/BLT/BGE/BLTU/BGEU, JAL and JALR; computes the actual target; compares the result against the prediction carried down the pipe; issues a registered redirect on mispredict.
- IF side: provides a combinational direction prediction from 2-bit saturating counters, which are trained on resolved conditional branches.

Parameters:
XLEN, 32, operand/PC width
BHT_ENTRIES, 64, number of 2-bit counters; power of 2, >=2
IDX_W, $clog2(BHT_ENTRIES), index width (derived, localparam)

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_if_pc  in  XLEN  fetch PC for prediction lookup
o_if_pred_taken  out  1  predicted direction (counter MSB)
i_ex_valid  in  1  EX holds a valid instruction
i_ex_pc  in  XLEN  PC of EX instruction
i_ex_rs1  in  XLEN  forwarded rs1
i_ex_rs2  in  XLEN  forwarded rs2
i_ex_imm  in  XLEN  sign-extended immediate
i_ex_funct3  in  3  branch condition code
i_ex_branch  in  1  conditional branch
i_ex_jal  in  1  JAL
i_ex_jalr  in  1  JALR
i_ex_pred_taken  in  1  prediction made at fetch
i_ex_pred_target  in  XLEN  next-PC fetch used when predicted taken
i_flush  in  1  kill EX instruction this cycle
o_redirect  out  1  mispredict, refetch from o_redirect_pc (registered)
o_redirect_pc  out  XLEN  correct next PC (registered)
o_taken  out  1  resolved direction of last resolved instruction (registered)
o_br_illegal  out  1  conditional branch with funct3 010/011 (registered)
o_stat_branches  out  32  resolved control-transfer count (see Optional Feature)
o_stat_mispred  out  32  mispredict count (see Optional Feature)

Behaviour:
- Resolve condition: res = i_ex_valid & ~i_flush & (i_ex_branch | i_ex_jal | i_ex_jalr). Exactly one of the three type bits is set when valid; if several are set, priority is jal > jalr > branch.
- Compare:
  - Signed less-than uses the sign/overflow of rs1-rs2.
  - Unsigned less-than uses the borrow of the XLEN+1-bit subtract.
  - funct3 mapping: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
  - funct3 010/011: taken=0, illegal=1, BHT not updated.
- Actual taken: jal/jalr = 1; branch = compare result.
- Actual target: branch/jal = pc+imm; jalr = (rs1+imm) & ~1. All adds are modulo 2^XLEN and wrap silently.
- fallthrough = pc+4.
- Mispredict = res & ((taken != pred_taken) | (taken & pred_target != target)).
- Registered outputs, latency 1 cycle after the EX cycle:
  - o_redirect <= mispredict.
  - o_redirect_pc <= taken ? target : fallthrough. Updated only when res; otherwise holds.
  - o_taken, o_br_illegal: updated only when res; otherwise hold.
- o_redirect is a single-cycle pulse; it deasserts next cycle unless another mispredict resolves.
- BHT index = pc[IDX_W+1:2] for both lookup and update.
- Lookup: o_if_pred_taken = bht[idx(i_if_pc)][1], combinational.
- Same-cycle update to the same index: lookup returns the pre-update value; no bypass.
- Update: only when res & i_ex_branch & legal funct3.
  - Counter +1 if taken, -1 if not taken.
  - Saturates at 2'b11 / 2'b00; no wrap.
  - jal/jalr never train the BHT.
- i_flush: the EX instruction has no effect (no redirect, no training, no state change). Flush and valid together count as flush.
- Reset:
  - All counters 2'b01 (weakly not-taken), so o_if_pred_taken=0 on every index.
  - o_redirect=0, o_redirect_pc=0, o_taken=0, o_br_illegal=0; stats=0.
  - Reset mid-operation discards any pending redirect and all training.
  - Reset has priority over res in the same cycle.

Optional Feature:
BRANCH_STATS_EN
- Defined: o_stat_branches increments on every res cycle; o_stat_mispred increments on every mispredict cycle. Both are 32-bit, saturating at 0xFFFFFFFF, cleared by i_rst.
- Undefined: no counter flops; both outputs are tied to 0. The port list is unchanged.

Test Plan:
- Reset, then sweep i_if_pc over 0x0..0xFC by 4 -> o_if_pred_taken=0 at all 64 indices.
- BLT (funct3 100), rs1=0xFFFFFFFF, rs2=0x1, pc=0x100, imm=0x20, pred_taken=0 -> next cycle o_redirect=1, o_redirect_pc=0x120, o_taken=1. Same with BLTU -> not taken, o_redirect=0.
- Train BEQ at pc=0x40 taken three times (pred/target correct after the first) -> counter 01->10->11->11 (saturates); o_if_pred_taken(0x40)=1 after the first update. Then three not-taken -> 11->10->01->00.
- JALR, rs1=0x1003, imm=0x4, pred_taken=1, pred_target=0x1006 -> target 0x1006, o_redirect=0, BHT unchanged. Pred_target=0x1008 instead -> o_redirect=1, pc 0x1006.
- Mispredicting BNE with i_flush=1 -> o_redirect=0, counter unchanged. funct3=010 -> o_br_illegal=1, o_taken=0, no training.
- With BRANCH_STATS_EN: 5 branches, 2 mispredicts -> stats 5/2. Assert i_rst mid-run -> both 0, o_redirect=0 the next cycle. Without the macro -> stats read 0 throughout.
